encrypt_seq: RTL
================

ENCRYPT_SEQ -- requirements
Module: encrypt_seq

Interface
REQ-001 Parameter: none local; DATAWIDTH, default 8 (test curve), operand width taken from shared parameters.vh.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 ephemeralKey  in  DATAWIDTH  scalar k.
REQ-006 publicKeyX_in, publicKeyY_in  in  DATAWIDTH  recipient public point Q.
REQ-007 Mx_in, My_in  in  DATAWIDTH  message point M.
REQ-008 busy  out  1  high from the cycle after accept until done.
REQ-009 done  out  1  one-cycle pulse, results valid.
REQ-010 C1x_out, C1y_out, C2x_out, C2y_out  out  DATAWIDTH each  ciphertext C1 = k*G, C2 = M + k*Q.

Function
REQ-011 States: IDLE, DBL_G, DBL_Q, ADD_G, ADD_Q, ADD_M, DONE.
REQ-012 IDLE with start=1: latch k, Q, M; set accumulators RG, RQ to infinity; bit index to DATAWIDTH-1; go DBL_G.
REQ-013 Scan all DATAWIDTH key bits MSB-first, including leading zeros; one point-unit operation per cycle.
REQ-014 Per bit: DBL_G (RG=2RG), DBL_Q (RQ=2RQ); if bit=1, ADD_G (RG+=G), ADD_Q (RQ+=Q); then next bit or, after bit 0, ADD_M.
REQ-015 ADD_M: C2 = M + RQ; C1 = RG; go DONE; DONE asserts done for one cycle, returns to IDLE.
REQ-016 Latency: done high exactly 2*DATAWIDTH + 2*popcount(k) + 2 cycles after the accepting edge.
REQ-017 Arithmetic mod shared prime P; point infinity carried as separate flag; infinity output encoded (0,0).
REQ-018 Doubling infinity or point with y=0 yields infinity; P + (-P) yields infinity; infinity + X yields X.
REQ-019 start while busy ignored; inputs changing during busy have no effect.
REQ-020 start in DONE cycle ignored; accepted from next IDLE cycle.
REQ-021 Outputs hold last result until next done; they change only in the DONE transition.

Reset
REQ-022 rst_n low: state IDLE, busy=0, done=0, all C* outputs 0, accumulators infinity; effective immediately, aborting any operation in progress, no done pulse.
REQ-023 First start accepted on first rising edge with rst_n high.

Configuration
REQ-024 Macro ECEG_KEYCHECK_EN defined: extra output err (1 bit, reset 0); k==0 skips scan, done after 2 cycles with err=1, outputs 0; RG or RQ infinity at ADD_M sets err=1 with done, outputs 0; err holds until next accept.
REQ-025 Macro undefined: no err port; k==0 runs full scan, giving C1=(0,0), C2=M.

Structure
REQ-026 parameters.vh holds DATAWIDTH, prime P, curve coefficient A, generator Gx/Gy, state encodings.
REQ-027 One sub-module ec_point_unit: combinational add/double mod P with infinity flags, op select, shared by all states.

Verification (curve y^2=x^3+2x+2 mod 17, G=(5,1), order 19, DATAWIDTH=8)
REQ-028 Q=(0,6), k=3, M=(5,1) -> C1=(10,6), C2=(10,6), done at cycle 22.
REQ-029 Q=(0,6), k=1, M=(5,1) -> C1=(5,1), C2=(13,7), done at cycle 20.
REQ-030 k=19, any Q -> C1 infinity; with ECEG_KEYCHECK_EN err=1 outputs 0; without, C1=(0,0), C2=M.
REQ-031 rst_n low mid-scan of REQ-028, then restart with REQ-029 inputs -> no done from first run, second result exact.
REQ-032 start pulsed every cycle during REQ-028 run -> single done, correct result, next run starts only after IDLE.

Source files
------------

// File: rtl/encrypt_seq_pkg.sv
// Shared curve constants, point/state types and mod-P field helpers for the ElGamal EC encryptor.
// Test curve y^2 = x^3 + 2x + 2 mod 17, generator G = (5,1) of order 19.
package encrypt_seq_pkg;

  localparam int                   DATAWIDTH = 8;
  localparam logic [DATAWIDTH-1:0] P         = 8'd17;
  localparam logic [DATAWIDTH-1:0] CURVE_A   = 8'd2;
  localparam logic [DATAWIDTH-1:0] GX        = 8'd5;
  localparam logic [DATAWIDTH-1:0] GY        = 8'd1;
  localparam logic [DATAWIDTH-1:0] INV_EXP   = P - 8'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DBL_G = 3'd1,
    DBL_Q = 3'd2,
    ADD_G = 3'd3,
    ADD_Q = 3'd4,
    ADD_M = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_DBL = 1'b1
  } pu_op_t;

  // Infinity travels as its own flag; coordinates of an infinite point are kept at zero.
  typedef struct packed {
    logic                 inf;
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] y;
  } point_t;

  localparam point_t INF_PT = '{inf: 1'b1, x: '0, y: '0};
  localparam point_t G_PT   = '{inf: 1'b0, x: GX, y: GY};

  function automatic logic [DATAWIDTH-1:0] mod_add(input logic [DATAWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] b);
    logic [DATAWIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DATAWIDTH-1:0];
  endfunction

  function automatic logic [DATAWIDTH-1:0] mod_sub(input logic [DATAWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] b);
    if (a >= b) return a - b;
    return a + (P - b);
  endfunction

  function automatic logic [DATAWIDTH-1:0] mod_mul(input logic [DATAWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] b);
    logic [2*DATAWIDTH-1:0] pr;
    pr = {{DATAWIDTH{1'b0}}, a} * {{DATAWIDTH{1'b0}}, b};
    pr = pr % {{DATAWIDTH{1'b0}}, P};
    return pr[DATAWIDTH-1:0];
  endfunction

  // Fermat inverse a^(P-2); the exponent is constant so this unrolls into a fixed multiplier chain.
  function automatic logic [DATAWIDTH-1:0] mod_inv(input logic [DATAWIDTH-1:0] a);
    logic [DATAWIDTH-1:0] r;
    r = DATAWIDTH'(1);
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      r = mod_mul(r, r);
      if (INV_EXP[i]) r = mod_mul(r, a);
    end
    return r;
  endfunction

endpackage

// File: rtl/encrypt_seq_point_unit.sv
// Combinational EC point add/double mod P with infinity flags; zero latency, no flow control.
// One instance is time-shared by every state of the scalar-multiply sequencer.
module ec_point_unit
  import encrypt_seq_pkg::*;
(
  input  pu_op_t op,
  input  point_t pa,
  input  point_t pb,
  output point_t res
);

  function automatic point_t pt_dbl(input point_t p);
    point_t               r;
    logic [DATAWIDTH-1:0] x2, num, lam, x3;
    r = INF_PT;
    if (!p.inf && (p.y != '0)) begin
      x2    = mod_mul(p.x, p.x);
      num   = mod_add(mod_add(x2, x2), mod_add(x2, CURVE_A));
      lam   = mod_mul(num, mod_inv(mod_add(p.y, p.y)));
      x3    = mod_sub(mod_mul(lam, lam), mod_add(p.x, p.x));
      r.inf = 1'b0;
      r.x   = x3;
      r.y   = mod_sub(mod_mul(lam, mod_sub(p.x, x3)), p.y);
    end
    return r;
  endfunction

  function automatic point_t pt_add(input point_t a, input point_t b);
    point_t               r;
    logic [DATAWIDTH-1:0] lam, x3;
    r = INF_PT;
    if (a.inf) begin
      r = b;
    end else if (b.inf) begin
      r = a;
    end else if (a.x == b.x) begin
      // Same x: either b = -a (sum is infinity) or b = a (tangent case).
      if (mod_add(a.y, b.y) != '0) r = pt_dbl(a);
    end else begin
      lam   = mod_mul(mod_sub(b.y, a.y), mod_inv(mod_sub(b.x, a.x)));
      x3    = mod_sub(mod_sub(mod_mul(lam, lam), a.x), b.x);
      r.inf = 1'b0;
      r.x   = x3;
      r.y   = mod_sub(mod_mul(lam, mod_sub(a.x, x3)), a.y);
    end
    return r;
  endfunction

  always_comb begin
    res = INF_PT;
    if (op == OP_DBL) res = pt_dbl(pa);
    else              res = pt_add(pa, pb);
  end

endmodule

// File: rtl/encrypt_seq.sv
// EC-ElGamal encryptor: C1 = k*G, C2 = M + k*Q; done pulses 2*W + 2*popcount(k) + 2 cycles after accept.
// start is only sampled in IDLE (ignored while busy); ECEG_KEYCHECK_EN adds an err output for degenerate keys.
module encrypt_seq
  import encrypt_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] ephemeralKey,
  input  logic [DATAWIDTH-1:0] publicKeyX_in,
  input  logic [DATAWIDTH-1:0] publicKeyY_in,
  input  logic [DATAWIDTH-1:0] Mx_in,
  input  logic [DATAWIDTH-1:0] My_in,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] C1x_out,
  output logic [DATAWIDTH-1:0] C1y_out,
  output logic [DATAWIDTH-1:0] C2x_out,
  output logic [DATAWIDTH-1:0] C2y_out
`ifdef ECEG_KEYCHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int BW = $clog2(DATAWIDTH);

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] k_q, k_d;
  point_t               q_q, q_d, m_q, m_d, rg_q, rg_d, rq_q, rq_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [DATAWIDTH-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
`ifdef ECEG_KEYCHECK_EN
  logic                 err_q, err_d, chk_q, chk_d;
`endif

  pu_op_t pu_op;
  point_t pu_a, pu_b, pu_res;
  logic   last_bit;

  ec_point_unit u_pu (
    .op (pu_op),
    .pa (pu_a),
    .pb (pu_b),
    .res(pu_res)
  );

  assign last_bit = (bit_q == '0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    q_d     = q_q;
    m_d     = m_q;
    rg_d    = rg_q;
    rq_d    = rq_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c1x_d   = c1x_q;
    c1y_d   = c1y_q;
    c2x_d   = c2x_q;
    c2y_d   = c2y_q;
`ifdef ECEG_KEYCHECK_EN
    err_d   = err_q;
    chk_d   = chk_q;
`endif
    pu_op   = OP_ADD;
    pu_a    = rg_q;
    pu_b    = G_PT;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d    = ephemeralKey;
          q_d    = '{inf: 1'b0, x: publicKeyX_in, y: publicKeyY_in};
          m_d    = '{inf: 1'b0, x: Mx_in, y: My_in};
          rg_d   = INF_PT;
          rq_d   = INF_PT;
          bit_d  = BW'(DATAWIDTH - 1);
          busy_d = 1'b1;
`ifdef ECEG_KEYCHECK_EN
          err_d   = 1'b0;
          state_d = (ephemeralKey == '0) ? ADD_M : DBL_G;
`else
          state_d = DBL_G;
`endif
        end
      end
      DBL_G: begin
        pu_op   = OP_DBL;
        pu_a    = rg_q;
        rg_d    = pu_res;
        state_d = DBL_Q;
      end
      DBL_Q: begin
        pu_op = OP_DBL;
        pu_a  = rq_q;
        rq_d  = pu_res;
        if (k_q[bit_q]) begin
          state_d = ADD_G;
        end else if (last_bit) begin
          state_d = ADD_M;
        end else begin
          bit_d   = bit_q - BW'(1);
          state_d = DBL_G;
        end
      end
      ADD_G: begin
        pu_a    = rg_q;
        pu_b    = G_PT;
        rg_d    = pu_res;
        state_d = ADD_Q;
      end
      ADD_Q: begin
        pu_a = rq_q;
        pu_b = q_q;
        rq_d = pu_res;
        if (last_bit) begin
          state_d = ADD_M;
        end else begin
          bit_d   = bit_q - BW'(1);
          state_d = DBL_G;
        end
      end
      ADD_M: begin
        // RQ is reused to carry C2 into DONE; degeneracy is judged on the pre-add accumulators.
        pu_a    = m_q;
        pu_b    = rq_q;
        rq_d    = pu_res;
`ifdef ECEG_KEYCHECK_EN
        chk_d   = rg_q.inf | rq_q.inf;
`endif
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        c1x_d   = rg_q.inf ? '0 : rg_q.x;
        c1y_d   = rg_q.inf ? '0 : rg_q.y;
        c2x_d   = rq_q.inf ? '0 : rq_q.x;
        c2y_d   = rq_q.inf ? '0 : rq_q.y;
`ifdef ECEG_KEYCHECK_EN
        if (chk_q) begin
          err_d = 1'b1;
          c1x_d = '0;
          c1y_d = '0;
          c2x_d = '0;
          c2y_d = '0;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      rg_q    <= INF_PT;
      rq_q    <= INF_PT;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c1x_q   <= '0;
      c1y_q   <= '0;
      c2x_q   <= '0;
      c2y_q   <= '0;
`ifdef ECEG_KEYCHECK_EN
      err_q   <= 1'b0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      q_q     <= q_d;
      m_q     <= m_d;
      rg_q    <= rg_d;
      rq_q    <= rq_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c1x_q   <= c1x_d;
      c1y_q   <= c1y_d;
      c2x_q   <= c2x_d;
      c2y_q   <= c2y_d;
`ifdef ECEG_KEYCHECK_EN
      err_q   <= err_d;
      chk_q   <= chk_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign C1x_out = c1x_q;
  assign C1y_out = c1y_q;
  assign C2x_out = c2x_q;
  assign C2y_out = c2y_q;
`ifdef ECEG_KEYCHECK_EN
  assign err     = err_q;
`endif

endmodule
